// File: rtl/mash111_network.sv
// Third-order MASH 1-1-1 modulator: three chained first-order accumulators plus noise cancellation.
// Optional dither LFSR on the stage-1 carry-in is enabled by defining NCDDSM_DITHER_EN.
module mash111_network #(
  parameter int P_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [P_WIDTH-1:0] i_frac_in,
  output logic [3:0]         o_network,
  output logic               o_valid
);

  logic [P_WIDTH-1:0] acc1_q, acc1_d;
  logic [P_WIDTH-1:0] acc2_q, acc2_d;
  logic [P_WIDTH-1:0] acc3_q, acc3_d;
  logic               c2_d1_q, c2_d1_d;
  logic               c3_d1_q, c3_d1_d;
  logic               c3_d2_q, c3_d2_d;
  logic [3:0]         network_q, network_d;
  logic               valid_q, valid_d;

  logic [P_WIDTH:0]   s1, s2, s3;
  logic               c1, c2, c3;
  logic               carry_in;
  logic [3:0]         y;

`ifdef NCDDSM_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;

  assign carry_in = lfsr_q[0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_en) begin
      lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 15'h0001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign carry_in = 1'b0;
`endif

  // Stages are chained in one cycle: each stage accumulates the previous stage's residue.
  always_comb begin
    s1 = {1'b0, acc1_q} + {1'b0, i_frac_in} + {{P_WIDTH{1'b0}}, carry_in};
    c1 = s1[P_WIDTH];
    s2 = {1'b0, acc2_q} + {1'b0, s1[P_WIDTH-1:0]};
    c2 = s2[P_WIDTH];
    s3 = {1'b0, acc3_q} + {1'b0, s2[P_WIDTH-1:0]};
    c3 = s3[P_WIDTH];
    // Modulo-16 arithmetic yields the correct two's-complement result in -3..+4.
    y = {3'b000, c1}
      + {3'b000, c2} - {3'b000, c2_d1_q}
      + {3'b000, c3} - {2'b00, c3_d1_q, 1'b0} + {3'b000, c3_d2_q};
  end

  always_comb begin
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    c2_d1_d   = c2_d1_q;
    c3_d1_d   = c3_d1_q;
    c3_d2_d   = c3_d2_q;
    network_d = network_q;
    valid_d   = i_en;
    if (i_en) begin
      acc1_d    = s1[P_WIDTH-1:0];
      acc2_d    = s2[P_WIDTH-1:0];
      acc3_d    = s3[P_WIDTH-1:0];
      c2_d1_d   = c2;
      c3_d1_d   = c3;
      c3_d2_d   = c3_d1_q;
      network_d = y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc1_q    <= '0;
      acc2_q    <= '0;
      acc3_q    <= '0;
      c2_d1_q   <= 1'b0;
      c3_d1_q   <= 1'b0;
      c3_d2_q   <= 1'b0;
      network_q <= 4'h0;
      valid_q   <= 1'b0;
    end else begin
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      c2_d1_q   <= c2_d1_d;
      c3_d1_q   <= c3_d1_d;
      c3_d2_q   <= c3_d2_d;
      network_q <= network_d;
      valid_q   <= valid_d;
    end
  end

  assign o_network = network_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_mash111_network.sv
// Self-checking bench for mash111_network: directed vectors, long-run mean checks, enable gating
// and randomized stimulus against an integer reference model of the MASH 1-1-1 equations.
module tb_mash111_network;

  localparam int     P_WIDTH = 16;
  localparam longint MOD     = 64'd1 << P_WIDTH;
`ifdef NCDDSM_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [P_WIDTH-1:0] frac;
  logic [3:0]         network;
  logic               valid;

  int total;
  int bad;

  mash111_network #(.P_WIDTH(P_WIDTH)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_frac_in (frac),
    .o_network (network),
    .o_valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint m_acc1, m_acc2, m_acc3;
  int     m_c2h, m_c3h1, m_c3h2;
  int     m_net, m_valid, m_lfsr;

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    m_c2h = 0; m_c3h1 = 0; m_c3h2 = 0;
    m_net = 0; m_valid = 0; m_lfsr = 1;
  endtask

  // One sample of the modulator: carries are the "sum reached 2^P" events of each accumulator.
  task automatic model_step(input bit step_en, input longint step_frac);
    longint s;
    int     c1, c2, c3, cin;
    if (!step_en) begin
      m_valid = 0;
      return;
    end
    cin = 0;
    if (DITHER) begin
      cin    = m_lfsr % 2;
      m_lfsr = ((m_lfsr * 2) % 32768) + (((m_lfsr / 16384) + (m_lfsr / 8192)) % 2);
    end
    s = m_acc1 + step_frac + cin; c1 = (s >= MOD) ? 1 : 0; m_acc1 = s % MOD;
    s = m_acc2 + m_acc1;          c2 = (s >= MOD) ? 1 : 0; m_acc2 = s % MOD;
    s = m_acc3 + m_acc2;          c3 = (s >= MOD) ? 1 : 0; m_acc3 = s % MOD;
    m_net   = c1 + (c2 - m_c2h) + (c3 - 2 * m_c3h1 + m_c3h2);
    m_c2h   = c2;
    m_c3h2  = m_c3h1;
    m_c3h1  = c3;
    m_valid = 1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int net_value();
    return int'($signed(network));
  endfunction

  task automatic apply_stimulus(input bit step_en, input logic [P_WIDTH-1:0] step_frac);
    @(negedge clk);
    en   = step_en;
    frac = step_frac;
    @(posedge clk);
    model_step(step_en, longint'(step_frac));
    #1;
    check_output("network_vs_model", net_value(), m_net);
    check_output("valid_vs_model", int'(valid), m_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit                 en;
    logic [P_WIDTH-1:0] frac;
    int                 exp_net;
    bit                 exp_valid;
  } vec_t;

  vec_t   vecs[10];
  int     cont_exp[$];
  int     sum, k, held;
  bit     seen_nonzero;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    frac  = '0;
    model_reset();

    vecs[0] = '{1'b1, 16'h8000,  0, 1'b1};
    vecs[1] = '{1'b1, 16'h8000,  2, 1'b1};
    vecs[2] = '{1'b1, 16'h8000, -1, 1'b1};
    vecs[3] = '{1'b1, 16'h8000,  1, 1'b1};
    vecs[4] = '{1'b0, 16'h1234,  1, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF,  1, 1'b0};
    vecs[6] = '{1'b1, 16'h8000,  0, 1'b1};
    vecs[7] = '{1'b1, 16'h8000,  2, 1'b1};
    vecs[8] = '{1'b1, 16'h8000, -1, 1'b1};
    vecs[9] = '{1'b1, 16'h8000,  1, 1'b1};

    #12;
    check_output("reset_network", net_value(), 0);
    check_output("reset_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run a stream, then drop reset mid-cycle with the strobe still active.
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 16'h8000);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_network", net_value(), 0);
    check_output("async_reset_valid", int'(valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset_hold_network", net_value(), 0);
    check_output("reset_hold_valid", int'(valid), 0);
    model_reset();
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;

`ifndef NCDDSM_DITHER_EN
    foreach (vecs[i]) begin
      @(negedge clk);
      en   = vecs[i].en;
      frac = vecs[i].frac;
      @(posedge clk);
      model_step(vecs[i].en, longint'(vecs[i].frac));
      #1;
      check_output($sformatf("vec%0d_network", i), net_value(), vecs[i].exp_net);
      check_output($sformatf("vec%0d_valid", i), int'(valid), int'(vecs[i].exp_valid));
    end

    do_reset();
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(1'b1, '0);
      check_output("zero_input_network", net_value(), 0);
      check_output("zero_input_valid", int'(valid), 1);
    end

    do_reset();
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      apply_stimulus(1'b1, 16'h8000);
      sum += net_value();
      check_output("half_range", int'(net_value() >= -3 && net_value() <= 4), 1);
    end
    check_output("half_sum_in_window", int'(sum >= 508 && sum <= 516), 1);

    do_reset();
    sum = 0;
    for (int i = 0; i < 4096; i++) begin
      apply_stimulus(1'b1, 16'hFFFF);
      sum += net_value();
      check_output("full_range", int'(net_value() >= -3 && net_value() <= 4), 1);
    end
    check_output("full_sum_in_window", int'(sum >= 4091 && sum <= 4099), 1);
`endif

    // Enable gating: the gated stream must reproduce the continuous stream sample for sample.
    do_reset();
    cont_exp.delete();
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 16'h4000);
      cont_exp.push_back(m_net);
    end
    do_reset();
    k = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 16'h4000);
      check_output("gated_vs_continuous", net_value(), cont_exp[k]);
      held = cont_exp[k];
      k++;
      for (int g = 0; g < 2; g++) begin
        apply_stimulus(1'b0, 16'(($urandom % 65536)));
        check_output("gap_hold_network", net_value(), held);
        check_output("gap_valid_low", int'(valid), 0);
      end
    end

    do_reset();
    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(($urandom % 4) != 0, 16'($urandom % 65536));
    end

`ifdef NCDDSM_DITHER_EN
    do_reset();
    sum = 0;
    seen_nonzero = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      apply_stimulus(1'b1, '0);
      sum += net_value();
      if (net_value() != 0) seen_nonzero = 1'b1;
    end
    check_output("dither_nonzero_seen", int'(seen_nonzero), 1);
    check_output("dither_sum_in_window", int'(sum >= -4 && sum <= 4), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
